// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 width codes used by loads and stores
//   - lsu_state_t : sequencer states
//   - err_cause_t : encoding of the err_cause_o field
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_cause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   mask       in  3   funct3 width code
//   offset     in  2   byte offset within the word (addr[1:0])
//   wdata      in  32  store data (rs2)
//   rword      in  32  raw word read from the bus
//   be         out 4   byte enables
//   bus_wdata  out 32  lane-replicated store data
//   rdata      out 32  extracted and sign/zero-extended load data
//   misaligned out 1   access crosses its natural alignment
//   illegal    out 1   mask is not a valid width code
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Halfword select only looks at offset[1]: an odd offset is flagged
  // misaligned and never reaches the bus.
  assign byte_sel = rword[{offset, 3'b000} +: 8];
  assign half_sel = rword[{offset[1], 4'b0000} +: 16];
  // Codes 000/001 are the signed variants; 100/101 the unsigned ones.
  assign sext     = ~mask[2];

  always_comb begin
    be         = 4'b0000;
    bus_wdata  = 32'h0;
    rdata      = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (mask)
      F3_B, F3_BU: begin
        be        = 4'b0001 << offset;
        bus_wdata = {4{wdata[7:0]}};
        rdata     = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << offset;
        bus_wdata  = {2{wdata[15:0]}};
        rdata      = {{16{sext & half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_W: begin
        be         = 4'b1111;
        bus_wdata  = wdata;
        rdata      = rword;
        misaligned = |offset;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer between the core decoder and a
// req/ack data bus. Stalls the core for the duration of an access and
// returns formatted load data in the single RESP cycle.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   mem_rd_i, mem_wr_i     decoded load / store
//   mask_i                 funct3 width code
//   addr_i, wdata_i        byte address, store data
//   stall_o                hold PC/instruction
//   rdata_o, rdata_valid_o formatted load data, valid in RESP for loads
//   err_o, err_cause_o     one-cycle fault pulse and its cause
//   bus_*                  request side of the data bus
//   bus_ack_i, bus_rdata_i completion and read word
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mask_q;
  logic [1:0]       off_q;
  logic             timed_out;
  logic [31:0]      rdata_q;

  logic [2:0]  a_mask;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_misaligned;
  logic        a_illegal;

  logic access;
  logic illegal_req;
  logic start;
  logic ack_hit;
  logic to_hit;

  // One aligner serves both ends of the transaction: in IDLE it steers the
  // incoming store, afterwards it formats the read word using the width
  // and offset latched at issue.
  assign a_mask = (state == IDLE) ? mask_i       : mask_q;
  assign a_off  = (state == IDLE) ? addr_i[1:0]  : off_q;

  lsu_align u_align (
    .mask       (a_mask),
    .offset     (a_off),
    .wdata      (wdata_i),
    .rword      (bus_rdata_i),
    .be         (a_be),
    .bus_wdata  (a_wdata),
    .rdata      (a_rdata),
    .misaligned (a_misaligned),
    .illegal    (a_illegal)
  );

  assign access      = mem_rd_i | mem_wr_i;
  // Unsigned widths only make sense for loads.
  assign illegal_req = a_illegal | (mem_rd_i & mem_wr_i) | (mem_wr_i & mask_i[2]);
  assign rdata_o     = rdata_q;

  // Combinational outputs are forced low while rst is held so the bus
  // request and stall drop the moment reset asserts.
  always_comb begin
    state_next    = state;
    stall_o       = 1'b0;
    err_o         = 1'b0;
    err_cause_o   = ERR_NONE;
    bus_req_o     = 1'b0;
    rdata_valid_o = 1'b0;
    start         = 1'b0;
    ack_hit       = 1'b0;
    to_hit        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (illegal_req) begin
              err_o       = 1'b1;
              err_cause_o = ERR_ILLEGAL;
            end else if (a_misaligned) begin
              err_o       = 1'b1;
              err_cause_o = ERR_MISALIGN;
            end else begin
              stall_o    = 1'b1;
              start      = 1'b1;
              state_next = REQ;
            end
          end
        end
        REQ: begin
          bus_req_o = 1'b1;
          stall_o   = 1'b1;
          // An ack on the last allowed cycle still wins over the timeout.
          if (bus_ack_i) begin
            ack_hit    = 1'b1;
            state_next = RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            to_hit     = 1'b1;
            state_next = RESP;
          end
        end
        RESP: begin
          state_next = IDLE;
          if (timed_out) begin
            err_o       = 1'b1;
            err_cause_o = ERR_TIMEOUT;
          end else begin
            rdata_valid_o = ~bus_we_o;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mask_q      <= 3'b000;
      off_q       <= 2'b00;
      timed_out   <= 1'b0;
      rdata_q     <= 32'h0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= 32'h0;
    end else begin
      state <= state_next;
      if (start) begin
        bus_we_o    <= mem_wr_i;
        bus_addr_o  <= {addr_i[31:2], 2'b00};
        bus_be_o    <= a_be;
        bus_wdata_o <= a_wdata;
        mask_q      <= mask_i;
        off_q       <= addr_i[1:0];
        cnt         <= '0;
        timed_out   <= 1'b0;
      end else if (state == REQ) begin
        if (ack_hit) begin
          // Stores leave the last load result in place.
          if (!bus_we_o) rdata_q <= a_rdata;
        end else if (to_hit) begin
          rdata_q   <= 32'h0;
          timed_out <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the single-cycle core's main control decoder and a variable-latency data-memory bus.
- Takes the decoded mem_rd/mem_wr/mask plus the ALU address and rs2 data, then runs a req/ack bus transaction.
- Stalls the core until the access completes and returns sign/zero-extended load data for writeback.
- Detects misaligned, illegal-width and timed-out accesses.

Parameters:
TIMEOUT, 255, maximum REQ cycles without bus_ack_i before abort (1..1023)
CNT_W, 10, width of the timeout counter; TIMEOUT must fit

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_rd_i  in  1  decoded load
mem_wr_i  in  1  decoded store
mask_i  in  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (rs2)
stall_o  out  1  hold PC and instruction
rdata_o  out  32  formatted load data
rdata_valid_o  out  1  load data valid (RESP cycle, loads only)
err_o  out  1  one-cycle fault pulse
err_cause_o  out  2  01 misaligned, 10 illegal width, 11 timeout; 00 when no fault
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  word-aligned address, {addr_i[31:2],2'b00}
bus_be_o  out  4  byte enables
bus_wdata_o  out  32  lane-replicated store data
bus_ack_i  in  1  completion; read data valid the same cycle
bus_rdata_i  in  32  read word

Behaviour:
Reset:
- All outputs 0, state IDLE, counter 0.
- Asynchronous assertion mid-transaction drops bus_req_o immediately; no completion and no error are reported.

FSM states: IDLE, REQ, RESP.

IDLE:
- Access = mem_rd_i | mem_wr_i.
- Illegal if mask_i is in {011, 110, 111}, or if mem_rd_i and mem_wr_i are both high, or if a store uses mask 100/101.
- Misaligned if H/HU with addr_i[0]=1, or W with addr_i[1:0]!=00.
- On a fault (illegal takes priority over misaligned):
  - err_o=1 with cause, combinational in this cycle.
  - stall_o=0, no bus activity, stay in IDLE.
- On a legal access:
  - stall_o=1 combinationally.
  - Register we, addr, be and wdata onto the bus outputs; next state REQ.
  - Counter cleared.

REQ:
- bus_req_o=1, stall_o=1; all bus_* outputs held stable.
- bus_ack_i=1: capture bus_rdata_i, next state RESP.
- Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack:
  - next state RESP, flagged as timeout.
  - bus_req_o deasserts on entry to RESP.
  - In RESP: err_o=1, cause 11, rdata_o=0.

RESP (exactly one cycle):
- bus_req_o=0, stall_o=0; the core commits the instruction this cycle.
- rdata_valid_o=1 only for a non-timed-out load.
- rdata_o holds until the next RESP.
- Next state is always IDLE; a new instruction's access is evaluated there.

Timing and bus rules:
- Minimum latency, ack in the first REQ cycle: stall asserted 2 cycles, data in cycle 3.
- bus_ack_i is ignored outside REQ.

Byte lanes (o = addr[1:0]):
- be: B = 0001<<o; H = 0011<<o; W = 1111.
- wdata: B = {4{wdata_i[7:0]}}, H = {2{wdata_i[15:0]}}, W = wdata_i.
- Load data: word >> (8*o), then sign-extend (000, 001) or zero-extend (100, 101) from bit 7/15; W is passed through.

Decomposition:
- Shared package riscv_pkg holds:
  - localparams for the funct3 width codes
  - lsu_state_t enum (IDLE, REQ, RESP)
  - err_cause_t enum (NONE, MISALIGN, ILLEGAL, TIMEOUT)
- One combinational sub-module, lsu_align:
  - inputs mask, offset, wdata, rword
  - outputs be, bus wdata, formatted rdata, misaligned flag, illegal flag
- lsu_ctrl keeps the FSM, counter and registers.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack on the 1st REQ cycle -> stall 2 cycles; RESP shows rdata_o=0xDEADBEEF, rdata_valid_o=1, bus_be_o=1111, bus_addr_o=0x100.
- LB addr 0x103 then LBU addr 0x103, rword 0x80XXXXXX -> LB gives 0xFFFFFF80, LBU gives 0x00000080; bus_be_o=1000 for both.
- SH addr 0x202, wdata 0x1234ABCD, ack after 3 wait cycles -> bus_we_o=1, bus_be_o=1100, bus_wdata_o=0xABCDABCD, req held 4 cycles, rdata_valid_o=0 in RESP.
- LW addr 0x101, then mask 011 -> each gives err_o=1 for one cycle with cause 01 and then 10, stall_o=0, bus_req_o never asserted.
- TIMEOUT=4, LW with ack never driven -> req high 4 cycles, then RESP with err_o=1, cause 11, rdata_o=0; back to IDLE.
- rst pulsed during REQ -> bus_req_o and stall_o fall asynchronously, no err_o; an access issued after reset completes normally.
